// File: rtl/hci_arbiter_predictor_pkg.sv
// Shared types and the wrapped HWPE bank-mask helper for the HCI arbiter priority predictor.
package verification_hci_package;

   localparam int STALL_W        = 8;
   localparam int MAX_BANKS      = 64;
   localparam int MAX_BANK_IDX_W = 6;

   typedef logic [STALL_W-1:0] stall_cnt_t;

   typedef enum logic {
      ST_NORMAL = 1'b0,
      ST_FLIP   = 1'b1
   } dom_state_e;

   // Banks base..base+width-1 modulo n_banks; a request at least as wide as the memory covers everything.
   function automatic logic [MAX_BANKS-1:0] hwpe_wrap_mask(input int unsigned base,
                                                          input int unsigned width,
                                                          input int unsigned n_banks);
      logic [MAX_BANKS-1:0] mask;
      mask = '0;
      for (int unsigned i = 0; i < MAX_BANKS; i++) begin
         if (width >= n_banks) begin
            if (i < n_banks) mask[MAX_BANK_IDX_W'(i)] = 1'b1;
         end else if (i < width) begin
            mask[MAX_BANK_IDX_W'((base + i) % n_banks)] = 1'b1;
         end
      end
      return mask;
   endfunction

endpackage

// File: rtl/hci_arb_prio_domain.sv
// One priority domain: consecutive-stall counter driving the NORMAL/FLIP state machine.
// The raw state bit is exported (1 = FLIP) so the top and any bound checker can observe it.
module hci_arb_prio_domain
   import verification_hci_package::*;
#(
   parameter int STALL_W = 8
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               clear,
   input  logic               stall,
   input  logic [STALL_W-1:0] max_stall,
   output logic               state
);

   dom_state_e         state_q, state_d;
   logic [STALL_W-1:0] cnt_q, cnt_d;

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= ST_NORMAL;
         cnt_q   <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
      end
   end

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      if (clear) begin
         state_d = ST_NORMAL;
         cnt_d   = '0;
      end else begin
         case (state_q)
            ST_NORMAL: begin
               if (stall) begin
                  // The stall that finds the counter at the limit is the one that triggers the flip.
                  if (cnt_q == max_stall) begin
                     state_d = ST_FLIP;
                     cnt_d   = '0;
                  end else begin
                     cnt_d = cnt_q + STALL_W'(1);
                  end
               end else begin
                  cnt_d = '0;
               end
            end
            ST_FLIP: begin
               state_d = ST_NORMAL;
               cnt_d   = '0;
            end
         endcase
      end
   end

   assign state = (state_q == ST_FLIP);

endmodule

// File: rtl/hci_arbiter_predictor.sv
// Predicts the HCI log/HWPE bank arbitration outcome and flags contradicting grants.
// Define HCI_ARB_PRED_CHECK_EN to build pending tracking, violation and protocol checking.
module hci_arbiter_predictor
   import verification_hci_package::*;
#(
   parameter int N_LOG          = 8,
   parameter int N_HWPE         = 1,
   parameter int N_BANKS        = 16,
   parameter int HWPE_WIDTH     = 4,
   parameter int BIT_BANK_INDEX = $clog2(N_BANKS),
   parameter int STALL_W        = 8,
   parameter int ARBITER_MODE   = 0
) (
   input  logic                             clk,
   input  logic                             rst,
   input  logic                             invert_prio_i,
   input  logic [STALL_W-1:0]               low_prio_max_stall_i,
   input  logic [N_LOG-1:0]                 log_req_i,
   input  logic [N_LOG*BIT_BANK_INDEX-1:0]  log_bank_i,
   input  logic [N_LOG-1:0]                 log_gnt_i,
   input  logic [N_HWPE-1:0]                hwpe_req_i,
   input  logic [N_HWPE*BIT_BANK_INDEX-1:0] hwpe_bank_i,
   input  logic [N_HWPE-1:0]                hwpe_gnt_i,
   output logic [N_BANKS-1:0]               conflict_o,
   output logic [N_BANKS-1:0]               hide_log_o,
   output logic [N_BANKS-1:0]               hide_hwpe_o,
   output logic [N_BANKS-1:0]               prio_hwpe_o,
   output logic                             violation_o,
   output logic                             proto_err_o,
   output logic [15:0]                      violation_cnt_o
);

   logic [N_BANKS-1:0]             log_mask, hwpe_mask, conflict, prio_hwpe;
   logic [N_HWPE-1:0][N_BANKS-1:0] hwpe_master_mask;
   logic                           inv_q, inv_change;

   always_comb begin
      log_mask = '0;
      for (int m = 0; m < N_LOG; m++) begin
         if (log_req_i[m]) log_mask[log_bank_i[m*BIT_BANK_INDEX +: BIT_BANK_INDEX]] = 1'b1;
      end
   end

   always_comb begin
      hwpe_mask        = '0;
      hwpe_master_mask = '0;
      for (int h = 0; h < N_HWPE; h++) begin
         if (hwpe_req_i[h]) begin
            hwpe_master_mask[h] = N_BANKS'(hwpe_wrap_mask(32'(hwpe_bank_i[h*BIT_BANK_INDEX +: BIT_BANK_INDEX]),
                                                          HWPE_WIDTH, N_BANKS));
         end
         hwpe_mask = hwpe_mask | hwpe_master_mask[h];
      end
   end

   assign conflict = log_mask & hwpe_mask;

   // A change of the static priority restarts every domain on the following edge.
   always_ff @(posedge clk) inv_q <= invert_prio_i;
   assign inv_change = invert_prio_i ^ inv_q;

   generate
      if (ARBITER_MODE == 2) begin : g_per_bank
         for (genvar b = 0; b < N_BANKS; b++) begin : g_dom
            logic flip;
            hci_arb_prio_domain #(.STALL_W(STALL_W)) u_dom (
               .clk       (clk),
               .rst       (rst),
               .clear     (inv_change),
               .stall     (conflict[b]),
               .max_stall (low_prio_max_stall_i),
               .state     (flip)
            );
            assign prio_hwpe[b] = invert_prio_i ^ flip;
         end
      end else begin : g_global
         logic flip, stall;
         assign stall = (ARBITER_MODE == 0) ? ((|log_mask) && (|hwpe_mask)) : (|conflict);
         hci_arb_prio_domain #(.STALL_W(STALL_W)) u_dom (
            .clk       (clk),
            .rst       (rst),
            .clear     (inv_change),
            .stall     (stall),
            .max_stall (low_prio_max_stall_i),
            .state     (flip)
         );
         assign prio_hwpe = {N_BANKS{invert_prio_i ^ flip}};
      end
   endgenerate

   assign conflict_o  = conflict;
   assign prio_hwpe_o = prio_hwpe;
   assign hide_log_o  = conflict & prio_hwpe;
   assign hide_hwpe_o = conflict & ~prio_hwpe;

`ifdef HCI_ARB_PRED_CHECK_EN
   logic [N_LOG-1:0]                      log_pend_q;
   logic [N_LOG-1:0][BIT_BANK_INDEX-1:0]  log_pend_bank_q;
   logic [N_HWPE-1:0]                     hwpe_pend_q;
   logic [N_HWPE-1:0][BIT_BANK_INDEX-1:0] hwpe_pend_bank_q;
   logic                                  viol, perr;
   logic [15:0]                           viol_cnt_q;

   always_comb begin
      viol = 1'b0;
      perr = 1'b0;
      for (int m = 0; m < N_LOG; m++) begin
         if (log_gnt_i[m] && hide_log_o[log_bank_i[m*BIT_BANK_INDEX +: BIT_BANK_INDEX]]) viol = 1'b1;
         if (log_pend_q[m] && log_req_i[m] &&
             (log_bank_i[m*BIT_BANK_INDEX +: BIT_BANK_INDEX] != log_pend_bank_q[m])) perr = 1'b1;
      end
      for (int h = 0; h < N_HWPE; h++) begin
         if (hwpe_gnt_i[h] && (|(hide_hwpe_o & hwpe_master_mask[h]))) viol = 1'b1;
         if (hwpe_pend_q[h] && hwpe_req_i[h] &&
             (hwpe_bank_i[h*BIT_BANK_INDEX +: BIT_BANK_INDEX] != hwpe_pend_bank_q[h])) perr = 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         log_pend_q       <= '0;
         log_pend_bank_q  <= '0;
         hwpe_pend_q      <= '0;
         hwpe_pend_bank_q <= '0;
         viol_cnt_q       <= '0;
      end else begin
         for (int m = 0; m < N_LOG; m++) begin
            if (log_pend_q[m]) begin
               if (log_gnt_i[m]) log_pend_q[m] <= 1'b0;
            end else if (log_req_i[m] && !log_gnt_i[m]) begin
               log_pend_q[m]      <= 1'b1;
               log_pend_bank_q[m] <= log_bank_i[m*BIT_BANK_INDEX +: BIT_BANK_INDEX];
            end
         end
         for (int h = 0; h < N_HWPE; h++) begin
            if (hwpe_pend_q[h]) begin
               if (hwpe_gnt_i[h]) hwpe_pend_q[h] <= 1'b0;
            end else if (hwpe_req_i[h] && !hwpe_gnt_i[h]) begin
               hwpe_pend_q[h]      <= 1'b1;
               hwpe_pend_bank_q[h] <= hwpe_bank_i[h*BIT_BANK_INDEX +: BIT_BANK_INDEX];
            end
         end
         if (viol && (viol_cnt_q != 16'hFFFF)) viol_cnt_q <= viol_cnt_q + 16'd1;
      end
   end

   assign violation_o     = viol;
   assign proto_err_o     = perr;
   assign violation_cnt_o = viol_cnt_q;
`else
   logic unused_check_inputs;
   assign unused_check_inputs = ^{log_gnt_i, hwpe_gnt_i, hwpe_master_mask};
   assign violation_o     = 1'b0;
   assign proto_err_o     = 1'b0;
   assign violation_cnt_o = '0;
`endif

endmodule

// File: tb/tb_hci_arbiter_predictor.sv
// Bench for hci_arbiter_predictor: one instance per arbitration mode, shared stimulus, queued expectations.
module tb_hci_arbiter_predictor;
   import verification_hci_package::*;

   localparam int N_LOG   = 8;
   localparam int N_HWPE  = 1;
   localparam int N_BANKS = 16;
   localparam int BI      = 4;
`ifdef HCI_ARB_PRED_CHECK_EN
   localparam bit CHECK_EN = 1'b1;
`else
   localparam bit CHECK_EN = 1'b0;
`endif

   logic                   clk = 1'b0;
   logic                   rst;
   logic                   invert_prio;
   stall_cnt_t             max_stall;
   logic [N_LOG-1:0]       log_req, log_gnt;
   logic [N_LOG*BI-1:0]    log_bank;
   logic [N_HWPE-1:0]      hwpe_req, hwpe_gnt;
   logic [N_HWPE*BI-1:0]   hwpe_bank;

   logic [N_BANKS-1:0] conflict  [3];
   logic [N_BANKS-1:0] hide_log  [3];
   logic [N_BANKS-1:0] hide_hwpe [3];
   logic [N_BANKS-1:0] prio_hwpe [3];
   logic               violation [3];
   logic               proto_err [3];
   logic [15:0]        viol_cnt  [3];

   logic [31:0] exp_q[$];
   int n_checks = 0;
   int n_pass   = 0;

   always #5 clk = ~clk;

   for (genvar g = 0; g < 3; g++) begin : g_dut
      hci_arbiter_predictor #(.ARBITER_MODE(g)) u_dut (
         .clk                  (clk),
         .rst                  (rst),
         .invert_prio_i        (invert_prio),
         .low_prio_max_stall_i (max_stall),
         .log_req_i            (log_req),
         .log_bank_i           (log_bank),
         .log_gnt_i            (log_gnt),
         .hwpe_req_i           (hwpe_req),
         .hwpe_bank_i          (hwpe_bank),
         .hwpe_gnt_i           (hwpe_gnt),
         .conflict_o           (conflict[g]),
         .hide_log_o           (hide_log[g]),
         .hide_hwpe_o          (hide_hwpe[g]),
         .prio_hwpe_o          (prio_hwpe[g]),
         .violation_o          (violation[g]),
         .proto_err_o          (proto_err[g]),
         .violation_cnt_o      (viol_cnt[g])
      );
   end

   // ---------------- driver tasks ----------------
   task automatic next_cycle();
      @(posedge clk);
      #1;
   endtask

   task automatic drive_idle();
      log_req = '0; log_bank = '0; log_gnt = '0;
      hwpe_req = '0; hwpe_bank = '0; hwpe_gnt = '0;
   endtask

   task automatic set_log(input int m, input int bank);
      log_req[m] = 1'b1;
      log_bank[m*BI +: BI] = BI'(bank);
   endtask

   task automatic set_hwpe(input int base);
      hwpe_req = 1'b1;
      hwpe_bank = BI'(base);
   endtask

   task automatic do_reset(input logic inv, input int stall_max);
      invert_prio = inv;
      max_stall = stall_cnt_t'(stall_max);
      drive_idle();
      rst = 1'b1;
      next_cycle();
      rst = 1'b0;
   endtask

   // ---------------- scenarios ----------------
   task automatic test_reset();
      logic [31:0] exp, got;
      do_reset(1'b0, 3);
      for (int g = 0; g < 3; g++) begin
         exp_q.push_back(32'h0);
         exp_q.push_back(32'h0);
         exp_q.push_back(32'h0);
      end
      @(negedge clk);
      for (int g = 0; g < 3; g++) begin
         exp = exp_q.pop_front(); got = {conflict[g], prio_hwpe[g]}; n_checks++;
         if (got !== exp) $display("FAIL reset_conf_prio m%0d: got %h want %h", g, got, exp); else n_pass++;
         exp = exp_q.pop_front(); got = {hide_log[g], hide_hwpe[g]}; n_checks++;
         if (got !== exp) $display("FAIL reset_hide m%0d: got %h want %h", g, got, exp); else n_pass++;
         exp = exp_q.pop_front(); got = {viol_cnt[g], 14'b0, violation[g], proto_err[g]}; n_checks++;
         if (got !== exp) $display("FAIL reset_check m%0d: got %h want %h", g, got, exp); else n_pass++;
      end
      next_cycle();
      invert_prio = 1'b1;
      for (int g = 0; g < 3; g++) exp_q.push_back({16'h0, 16'hFFFF});
      @(negedge clk);
      for (int g = 0; g < 3; g++) begin
         exp = exp_q.pop_front(); got = {conflict[g], prio_hwpe[g]}; n_checks++;
         if (got !== exp) $display("FAIL reset_idle_invert m%0d: got %h want %h", g, got, exp); else n_pass++;
      end
      next_cycle();
   endtask

   task automatic test_global_flip();
      logic [31:0] exp, got;
      bit hide_h [6] = '{1, 1, 1, 0, 1, 1};
      do_reset(1'b0, 2);
      set_log(0, 3);
      set_hwpe(3);
      for (int c = 0; c < 6; c++) begin
         for (int g = 0; g < 3; g++)
            exp_q.push_back(hide_h[c] ? {16'h0, 16'h0008} : {16'h0008, 16'h0});
         exp_q.push_back({16'h0008, hide_h[c] ? 16'h0000 : 16'hFFFF});
         @(negedge clk);
         for (int g = 0; g < 3; g++) begin
            exp = exp_q.pop_front(); got = {hide_log[g], hide_hwpe[g]}; n_checks++;
            if (got !== exp) $display("FAIL flip_hide m%0d c%0d: got %h want %h", g, c, got, exp); else n_pass++;
         end
         exp = exp_q.pop_front(); got = {conflict[1], prio_hwpe[1]}; n_checks++;
         if (got !== exp) $display("FAIL flip_conf_prio c%0d: got %h want %h", c, got, exp); else n_pass++;
         next_cycle();
      end
   endtask

   task automatic test_wrap_mask();
      logic [31:0] exp, got;
      int          b1   [7] = '{1, 4, 0, 15, 13, 2, 1};
      int          b2   [7] = '{-1, -1, -1, -1, -1, -1, 14};
      logic [15:0] want [7] = '{16'h0002, 16'h0000, 16'h0001, 16'h8000, 16'h0000, 16'h0000, 16'h4002};
      do_reset(1'b0, 255);
      for (int c = 0; c < 7; c++) begin
         drive_idle();
         set_hwpe(14);
         set_log(0, b1[c]);
         if (b2[c] >= 0) set_log(3, b2[c]);
         exp_q.push_back({want[c], want[c]});
         @(negedge clk);
         exp = exp_q.pop_front(); got = {conflict[1], hide_hwpe[1]}; n_checks++;
         if (got !== exp) $display("FAIL wrap_conflict row%0d: got %h want %h", c, got, exp); else n_pass++;
         next_cycle();
      end
   endtask

   task automatic test_per_bank();
      logic [31:0] exp, got;
      logic [15:0] m1_prio [7] = '{16'h0, 16'h0, 16'hFFFF, 16'h0, 16'h0, 16'hFFFF, 16'h0};
      logic [15:0] m2_prio [7] = '{16'h0, 16'h0, 16'h0004, 16'h0020, 16'h0, 16'h0004, 16'h0020};
      do_reset(1'b0, 1);
      set_hwpe(2);
      set_log(0, 2);
      for (int c = 0; c < 7; c++) begin
         if (c == 1) set_log(1, 5);
         exp_q.push_back({m1_prio[c], m2_prio[c]});
         @(negedge clk);
         exp = exp_q.pop_front(); got = {prio_hwpe[1], prio_hwpe[2]}; n_checks++;
         if (got !== exp) $display("FAIL per_bank_prio c%0d: got %h want %h", c, got, exp); else n_pass++;
         next_cycle();
      end
   endtask

   task automatic test_any_request_stall();
      logic [31:0] exp, got;
      do_reset(1'b0, 0);
      set_log(0, 0);
      set_hwpe(8);
      for (int c = 0; c < 6; c++) begin
         exp_q.push_back({16'h0, (c % 2 == 1) ? 16'hFFFF : 16'h0000});
         exp_q.push_back(32'h0);
         @(negedge clk);
         exp = exp_q.pop_front(); got = {conflict[0], prio_hwpe[0]}; n_checks++;
         if (got !== exp) $display("FAIL mode0_toggle c%0d: got %h want %h", c, got, exp); else n_pass++;
         exp = exp_q.pop_front(); got = {prio_hwpe[1], prio_hwpe[2]}; n_checks++;
         if (got !== exp) $display("FAIL mode0_others_idle c%0d: got %h want %h", c, got, exp); else n_pass++;
         next_cycle();
      end
   endtask

   task automatic test_invert_change();
      logic [31:0] exp, got;
      bit hl [7] = '{0, 1, 1, 1, 1, 0, 1};
      do_reset(1'b0, 2);
      set_log(0, 3);
      set_hwpe(3);
      for (int c = 0; c < 7; c++) begin
         if (c == 1) invert_prio = 1'b1;
         exp_q.push_back({hl[c] ? 16'h0008 : 16'h0000, hl[c] ? 16'hFFFF : 16'h0000});
         exp_q.push_back({16'h0, hl[c] ? 16'h0008 : 16'h0000});
         @(negedge clk);
         exp = exp_q.pop_front(); got = {hide_log[1], prio_hwpe[1]}; n_checks++;
         if (got !== exp) $display("FAIL invert_m1 c%0d: got %h want %h", c, got, exp); else n_pass++;
         exp = exp_q.pop_front(); got = {16'h0, hide_log[2]}; n_checks++;
         if (got !== exp) $display("FAIL invert_m2 c%0d: got %h want %h", c, got, exp); else n_pass++;
         next_cycle();
      end
   endtask

   task automatic test_reset_mid_stall();
      logic [31:0] exp, got;
      bit hl [8] = '{0, 0, 0, 0, 0, 0, 1, 0};
      do_reset(1'b0, 2);
      set_log(0, 3);
      set_hwpe(3);
      for (int c = 0; c < 8; c++) begin
         rst = (c == 2);
         exp_q.push_back({hl[c] ? 16'h0008 : 16'h0000, hl[c] ? 16'h0008 : 16'h0000});
         @(negedge clk);
         exp = exp_q.pop_front(); got = {hide_log[1], hide_log[2]}; n_checks++;
         if (got !== exp) $display("FAIL reset_mid_stall c%0d: got %h want %h", c, got, exp); else n_pass++;
         next_cycle();
      end
      rst = 1'b0;
   endtask

   task automatic test_checks();
      logic [31:0] exp, got;
      logic        v_exp [4] = '{1, 0, 1, 0};
      logic [15:0] c_exp [4] = '{16'd0, 16'd1, 16'd1, 16'd2};
      int          pbank [7] = '{7, 8, 7, 9, 9, 2, 4};
      logic        pgnt  [7] = '{0, 0, 1, 0, 0, 0, 0};
      logic        p_exp [7] = '{0, 1, 0, 0, 0, 1, 0};
      do_reset(1'b1, 255);
      for (int c = 0; c < 4; c++) begin
         drive_idle();
         if (c < 3) begin set_log(0, 3); set_hwpe(3); end
         log_gnt[0] = (c == 0);
         hwpe_gnt   = (c == 2);
         if (c == 2) invert_prio = 1'b0;
         exp_q.push_back({CHECK_EN ? c_exp[c] : 16'h0, 14'b0, CHECK_EN & v_exp[c], 1'b0});
         @(negedge clk);
         exp = exp_q.pop_front(); got = {viol_cnt[1], 14'b0, violation[1], proto_err[1]}; n_checks++;
         if (got !== exp) $display("FAIL violation c%0d: got %h want %h", c, got, exp); else n_pass++;
         next_cycle();
      end
      do_reset(1'b0, 255);
      for (int c = 0; c < 7; c++) begin
         if (c == 6) begin
            rst = 1'b1;
            next_cycle();
            rst = 1'b0;
         end
         drive_idle();
         set_log(1, pbank[c]);
         log_gnt[1] = pgnt[c];
         exp_q.push_back({16'h0, 14'b0, 1'b0, CHECK_EN & p_exp[c]});
         @(negedge clk);
         exp = exp_q.pop_front(); got = {viol_cnt[1], 14'b0, violation[1], proto_err[1]}; n_checks++;
         if (got !== exp) $display("FAIL proto_err c%0d: got %h want %h", c, got, exp); else n_pass++;
         next_cycle();
      end
   endtask

   // ---------------- sequence and report ----------------
   initial begin
      rst = 1'b1;
      invert_prio = 1'b0;
      max_stall = '0;
      drive_idle();
      next_cycle();
      test_reset();
      test_global_flip();
      test_wrap_mask();
      test_per_bank();
      test_any_request_stall();
      test_invert_change();
      test_reset_mid_stall();
      test_checks();
      if (exp_q.size() != 0) begin
         n_checks++;
         $display("FAIL scoreboard_drain: got %0d entries left want 0", exp_q.size());
      end
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout want completion");
      $fatal(1, "watchdog expired");
   end

endmodule
